// File: rtl/circ_smpl_queue.sv
// circ_smpl_queue: decimating circular sample store that replays the newest TAPS samples,
// oldest first, as a back-to-back capable burst for the FIR engine.
module circ_smpl_queue #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 1024,
    parameter int TAPS  = 1021,
    parameter int DECIM = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             wrt_smpl,
    input  logic [WIDTH-1:0] new_smpl,
    output logic [WIDTH-1:0] smpl_out,
    output logic             sequencing,
    output logic             smpl_last,
    output logic             full,
    output logic             overrun
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(TAPS + 1);
    localparam int DW = DECIM > 1 ? $clog2(DECIM) : 1;

    typedef enum logic {IDLE, BURST} state_t;

    if (DEPTH < TAPS + 1 || TAPS < 1 || (DEPTH & (DEPTH - 1)) != 0 || DECIM < 1 || DECIM > 16) begin : g_bad_cfg
        $error("circ_smpl_queue: illegal WIDTH/DEPTH/TAPS/DECIM combination");
    end

    logic [WIDTH-1:0] ram [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr, pend_start, rd_addr, start;
    logic [CW-1:0]    count, iss_cnt;
    logic [DW-1:0]    decim_cnt;
    logic             pending, rd_vld, rd_last, accept, trigger, last_issue;
    state_t           state, state_nx;

    assign accept     = wrt_smpl && !clr && decim_cnt == DW'(DECIM - 1);
    assign trigger    = accept && count >= CW'(TAPS - 1);
    assign start      = wr_ptr - AW'(TAPS - 1);
    assign last_issue = state == BURST && iss_cnt == CW'(TAPS - 1);
    assign full       = count == CW'(TAPS);

    always_comb begin
        state_nx = state;
        if (state == IDLE)
            state_nx = trigger ? BURST : IDLE;
        else if (last_issue && !pending && !trigger)
            state_nx = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            count      <= '0;
            decim_cnt  <= '0;
            rd_ptr     <= '0;
            iss_cnt    <= '0;
            pending    <= 1'b0;
            pend_start <= '0;
            overrun    <= 1'b0;
            rd_vld     <= 1'b0;
            rd_last    <= 1'b0;
            rd_addr    <= '0;
            sequencing <= 1'b0;
            smpl_last  <= 1'b0;
        end else if (clr) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            count      <= '0;
            decim_cnt  <= '0;
            rd_ptr     <= '0;
            iss_cnt    <= '0;
            pending    <= 1'b0;
            pend_start <= '0;
            overrun    <= 1'b0;
            rd_vld     <= 1'b0;
            rd_last    <= 1'b0;
            rd_addr    <= '0;
            sequencing <= 1'b0;
            smpl_last  <= 1'b0;
        end else begin
            state <= state_nx;
            if (wrt_smpl)
                decim_cnt <= accept ? '0 : decim_cnt + 1'b1;
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (!full)
                    count <= count + 1'b1;
            end
            rd_vld  <= state == BURST;
            rd_last <= last_issue;
            if (state == BURST)
                rd_addr <= rd_ptr;
            if (state == IDLE) begin
                if (trigger)
                    rd_ptr <= start;
            end else if (last_issue) begin
                // a trigger landing on the final issue takes the freed slot, so no overrun here
                iss_cnt <= '0;
                rd_ptr  <= pending ? pend_start : start;
                pending <= pending && trigger;
                if (trigger)
                    pend_start <= start;
            end else begin
                rd_ptr  <= rd_ptr + 1'b1;
                iss_cnt <= iss_cnt + 1'b1;
                if (trigger) begin
                    if (pending)
                        overrun <= 1'b1;
                    else begin
                        pending    <= 1'b1;
                        pend_start <= start;
                    end
                end
            end
            sequencing <= rd_vld;
            smpl_last  <= rd_last;
        end
    end

    // RAM has no reset; the read register lines up with sequencing
    always_ff @(posedge clk) begin
        if (accept)
            ram[wr_ptr] <= new_smpl;
        smpl_out <= ram[rd_addr];
    end
endmodule

// File: tb/tb_circ_smpl_queue.sv
// tb_circ_smpl_queue: randomized and directed checks of circ_smpl_queue against a
// schedule-level model (sample history plus per-cycle expected burst outputs).
module tb_circ_smpl_queue;
    localparam int W = 16, D = 8, T = 5, DM = 1;

    logic clk = 0, rst_n = 0, clr = 0, wrt_smpl = 0;
    logic [W-1:0] new_smpl = '0;
    logic [W-1:0] smpl_out, out3;
    logic sequencing, smpl_last, full, overrun, seq3, last3, full3, ovr3;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    circ_smpl_queue #(.WIDTH(W), .DEPTH(D), .TAPS(T), .DECIM(DM)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .wrt_smpl(wrt_smpl), .new_smpl(new_smpl),
        .smpl_out(smpl_out), .sequencing(sequencing), .smpl_last(smpl_last),
        .full(full), .overrun(overrun));

    circ_smpl_queue #(.WIDTH(W), .DEPTH(D), .TAPS(T), .DECIM(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .wrt_smpl(wrt_smpl), .new_smpl(new_smpl),
        .smpl_out(out3), .sequencing(seq3), .smpl_last(last3),
        .full(full3), .overrun(ovr3));

    // model: accepted-sample history and a per-edge table of expected burst outputs
    logic [W-1:0] hist[$];
    logic [W-1:0] exp_d[int];
    bit           exp_l[int];
    int  e = 0, last_first = -100, last_end = -100, m_dc = 0, first_o;
    bit  m_ovr = 0;

    logic [W-1:0] seen[$], seen3[$];
    int  first_seq_e = 0, run = 0, max_run = 0, last3_val = -1, wr_e = 0;
    bit  prev_seq = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, exp, e);
        end
    endtask

    task automatic chk_win(input string nm, input int idx, input int lo, input int hi);
        for (int v = lo; v <= hi; v++) begin
            chk(nm, idx < seen.size() ? int'(seen[idx]) : -1, v);
            idx++;
        end
    endtask

    task automatic flush();
        hist.delete();
        exp_d.delete();
        exp_l.delete();
        last_first = -100;
        last_end = -100;
        m_dc = 0;
        m_ovr = 0;
    endtask

    // a trigger at edge n outputs from n+2, or right after the last scheduled burst;
    // it is dropped when a scheduled burst has not yet begun issuing by edge n+1
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            flush();
        else begin
            e++;
            if (clr)
                flush();
            else if (wrt_smpl) begin
                if (m_dc != DM - 1)
                    m_dc++;
                else begin
                    m_dc = 0;
                    hist.push_back(new_smpl);
                    if (hist.size() > T)
                        hist.delete(0);
                    if (hist.size() == T) begin
                        if (last_first >= e + 3)
                            m_ovr = 1;
                        else begin
                            first_o = (last_end + 1 > e + 2) ? last_end + 1 : e + 2;
                            for (int i = 0; i < T; i++) begin
                                exp_d[first_o + i] = hist[i];
                                exp_l[first_o + i] = (i == T - 1);
                            end
                            last_first = first_o;
                            last_end = first_o + T - 1;
                        end
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        bit es;
        es = exp_d.exists(e);
        chk("sequencing", int'(sequencing), int'(es));
        chk("smpl_last", int'(smpl_last), es ? int'(exp_l[e]) : 0);
        chk("full", int'(full), int'(hist.size() == T));
        chk("overrun", int'(overrun), int'(m_ovr));
        if (es)
            chk("smpl_out", int'(smpl_out), int'(exp_d[e]));
        if (sequencing) begin
            seen.push_back(smpl_out);
            if (!prev_seq)
                first_seq_e = e;
        end
        prev_seq = sequencing;
        run = sequencing ? run + 1 : 0;
        if (run > max_run)
            max_run = run;
        if (seq3) begin
            seen3.push_back(out3);
            if (last3)
                last3_val = int'(out3);
        end
    end

    task automatic drive(input logic w, input logic [W-1:0] v, input logic c);
        @(negedge clk);
        wrt_smpl = w;
        new_smpl = v;
        clr = c;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, '0, 1'b0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_seq", int'(sequencing), 0);
        chk("rst_full", int'(full), 0);
        chk("rst_ovr", int'(overrun), 0);
        chk("rst_last", int'(smpl_last), 0);
        rst_n = 1;

        for (int v = 1; v <= 4; v++) begin
            drive(1'b1, W'(v), 1'b0);
            idle(3);
        end
        chk("fill4_full", int'(full), 0);
        chk("fill4_seq", seen.size(), 0);
        drive(1'b1, W'(5), 1'b0);
        idle(1);
        wr_e = e;
        idle(9);
        chk("fill_full", int'(full), 1);
        chk("fill_latency", first_seq_e - wr_e, 2);
        chk("fill_n", seen.size(), 5);
        chk_win("fill_win", 0, 1, 5);

        for (int v = 6; v <= 12; v++) begin
            seen.delete();
            drive(1'b1, W'(v), 1'b0);
            idle(9);
            chk("slide_n", seen.size(), 5);
            chk_win("slide_win", 0, v - 4, v);
        end

        drive(1'b0, '0, 1'b1);
        for (int v = 1; v <= 5; v++) begin
            drive(1'b1, W'(v), 1'b0);
            idle(3);
        end
        idle(8);
        seen.delete();
        max_run = 0;
        drive(1'b1, W'(6), 1'b0);
        idle(1);
        drive(1'b1, W'(7), 1'b0);
        idle(16);
        chk("b2b_n", seen.size(), 10);
        chk_win("b2b_first", 0, 2, 6);
        chk_win("b2b_second", 5, 3, 7);
        chk("b2b_contig", max_run, 10);
        chk("b2b_ovr", int'(overrun), 0);

        drive(1'b0, '0, 1'b1);
        for (int v = 1; v <= 4; v++) begin
            drive(1'b1, W'(v), 1'b0);
            idle(3);
        end
        seen.delete();
        drive(1'b1, W'(5), 1'b0);
        idle(4);
        drive(1'b1, W'(6), 1'b0);
        drive(1'b1, W'(7), 1'b0);
        drive(1'b1, W'(8), 1'b0);
        idle(20);
        chk("ovr_n", seen.size(), 15);
        chk_win("ovr_b1", 0, 1, 5);
        chk_win("ovr_b2", 5, 2, 6);
        chk_win("ovr_b3", 10, 3, 7);
        chk("ovr_flag", int'(overrun), 1);
        drive(1'b1, W'(9), 1'b0);
        idle(10);
        chk_win("ovr_after", 15, 5, 9);
        chk("ovr_sticky", int'(overrun), 1);
        drive(1'b0, '0, 1'b1);
        idle(1);
        chk("ovr_clr", int'(overrun), 0);

        for (int v = 1; v <= 4; v++) begin
            drive(1'b1, W'(v), 1'b0);
            idle(3);
        end
        drive(1'b1, W'(5), 1'b0);
        idle(3);
        drive(1'b1, W'(99), 1'b1);
        idle(1);
        chk("clr_seq", int'(sequencing), 0);
        chk("clr_full", int'(full), 0);
        seen.delete();
        for (int v = 10; v <= 14; v++) begin
            drive(1'b1, W'(v), 1'b0);
            idle(3);
        end
        idle(6);
        chk("clr_refill_n", seen.size(), 5);
        chk_win("clr_refill", 0, 10, 14);

        drive(1'b1, W'(15), 1'b0);
        idle(4);
        chk("arst_pre_seq", int'(sequencing), 1);
        #2 rst_n = 0;
        #1;
        chk("arst_seq", int'(sequencing), 0);
        chk("arst_full", int'(full), 0);
        @(negedge clk);
        rst_n = 1;
        seen.delete();
        for (int v = 21; v <= 25; v++) begin
            drive(1'b1, W'(v), 1'b0);
            idle(3);
        end
        idle(6);
        chk("arst_refill_n", seen.size(), 5);
        chk_win("arst_refill", 0, 21, 25);

        for (int k = 0; k < 300; k++) begin
            drive(1'b1, W'($urandom), $urandom_range(0, 30) == 0);
            idle($urandom_range(2, 8));
        end
        idle(20);

        drive(1'b0, '0, 1'b1);
        idle(1);
        seen3.delete();
        for (int v = 1; v <= 15; v++) begin
            drive(1'b1, W'(v), 1'b0);
            idle(3);
            if (v == 12)
                chk("d3_part_full", int'(full3), 0);
        end
        idle(10);
        chk("d3_n", seen3.size(), 5);
        for (int k = 0; k < 5; k++)
            chk("d3_val", k < seen3.size() ? int'(seen3[k]) : -1, 3 * (k + 1));
        chk("d3_last", last3_val, 15);
        chk("d3_full", int'(full3), 1);
        chk("d3_ovr", int'(ovr3), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
